// File: rtl/sprite_pkg.sv
// Shared constants, FSM state type and orientation-to-row mapping for the
// Rojobot sprite animation scheduler.
package sprite_pkg;
  localparam int SPRITE_COLS    = 34;
  localparam int SPRITE_ROWS    = 34;
  localparam int NUM_FRAME_COLS = 3;
  localparam int NUM_FRAME_ROWS = 8;
  localparam int IDLE_COL       = 1;
  localparam int ROW_STRIDE     = SPRITE_ROWS * NUM_FRAME_COLS * SPRITE_COLS;

  typedef enum logic {IDLE, RUN} state_e;

  function automatic logic [2:0] orient2row(input logic [2:0] orient);
    logic [2:0] row;
    case (orient)
      3'd0:    row = 3'd1;
      3'd1:    row = 3'd7;
      3'd2:    row = 3'd3;
      3'd3:    row = 3'd5;
      3'd4:    row = 3'd0;
      3'd5:    row = 3'd4;
      3'd6:    row = 3'd2;
      default: row = 3'd6;
    endcase
    return row;
  endfunction
endpackage

// File: rtl/anim_timer.sv
// Loadable down-counter; expire_o pulses on the enabled cycle it sits at zero,
// and the counter reloads in that same cycle.
module anim_timer #(
  parameter int          W       = 24,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] reload_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !load_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)        cnt_d = reload_i;
    else if (expire_o) cnt_d = reload_i;
    else if (en_i)     cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= RST_VAL;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation scheduler: ping-pong column stepping, orientation row, and
// vblank-aligned commit. Define SPRITE_ANIM_SPEED_EN to scale step rate by speed.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int ANIMATION_COUNTDOWN = 8_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblank_tick,
  input  logic [7:0]  BotInfo_reg,
  output logic [1:0]  frame_col,
  output logic [2:0]  frame_row,
  output logic [31:0] frame_base_addr,
  output logic        frame_update
);
  localparam int          CNT_W    = $clog2(ANIMATION_COUNTDOWN + 1);
  localparam logic [1:0]  LAST_COL = 2'(NUM_FRAME_COLS - 1);
  localparam logic [1:0]  IDLE_C   = 2'(IDLE_COL);
  localparam logic [31:0] RST_BASE = 32'(ROW_STRIDE + IDLE_COL * SPRITE_COLS);

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic        dir_q, dir_d;          // 0 = +1, 1 = -1
  logic [1:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic [31:0] base_q, base_d;
  logic        upd_q, upd_d;

  logic [3:0]       speed;
  logic             moving, expire;
  logic [CNT_W-1:0] reload;

  assign speed  = BotInfo_reg[7:4];
  assign moving = (speed != 4'd0);

`ifdef SPRITE_ANIM_SPEED_EN
  logic [2:0] shamt;
  always_comb begin
    shamt = 3'd0;
    if (speed > 4'd8)       shamt = 3'd7;
    else if (speed != 4'd0) shamt = 3'(speed - 4'd1);
  end
  assign reload = CNT_W'(ANIMATION_COUNTDOWN) >> shamt;
`else
  assign reload = CNT_W'(ANIMATION_COUNTDOWN);
`endif

  // Held at reload while idle so the first RUN step takes a full period.
  anim_timer #(
    .W       (CNT_W),
    .RST_VAL (CNT_W'(ANIMATION_COUNTDOWN))
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (state_q == RUN),
    .load_i   (state_q == IDLE),
    .reload_i (reload),
    .expire_o (expire)
  );

  // Ends force the direction, so a stale dir can never push col out of range.
  logic       down, dir_step;
  logic [1:0] col_step;
  always_comb begin
    down     = (col_q >= LAST_COL) || (dir_q && col_q != 2'd0);
    col_step = down ? col_q - 2'd1 : col_q + 2'd1;
    dir_step = (col_step == LAST_COL) ? 1'b1 : (col_step == 2'd0) ? 1'b0 : down;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dir_d     = dir_q;
    col_d     = col_q;
    row_d     = row_q;
    base_d    = base_q;
    upd_d     = 1'b0;

    case (state_q)
      IDLE: begin
        pending_d = 1'b0;
        if (moving) begin
          state_d = RUN;
          dir_d   = 1'b0;
        end
      end
      default: begin
        if (expire) pending_d = 1'b1;
        if (!moving) begin
          state_d   = IDLE;
          pending_d = 1'b0;
        end
      end
    endcase

    if (vblank_tick) begin
      row_d = orient2row(BotInfo_reg[2:0]);
      if (state_q == IDLE || !moving) begin
        col_d = IDLE_C;
        dir_d = 1'b0;
      end else if (pending_q || expire) begin
        col_d     = col_step;
        dir_d     = dir_step;
        pending_d = 1'b0;
      end
      base_d = 32'(row_d) * ROW_STRIDE + 32'(col_d) * SPRITE_COLS;
      upd_d  = (col_d != col_q) || (row_d != row_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      dir_q     <= 1'b0;
      col_q     <= IDLE_C;
      row_q     <= 3'd1;
      base_q    <= RST_BASE;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      dir_q     <= dir_d;
      col_q     <= col_d;
      row_q     <= row_d;
      base_q    <= base_d;
      upd_q     <= upd_d;
    end
  end

  assign frame_col       = col_q;
  assign frame_row       = row_q;
  assign frame_base_addr = base_q;
  assign frame_update    = upd_q;
endmodule
